uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_receiver.sv | 184 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding, oversample constants, divider helper.
// Latency: n/a (package only).
// Backpressure: n/a. Optional parity state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK  = 4'd7;   // 8th tick: middle of the start bit
  localparam logic [3:0] LAST_TICK = 4'd15;  // 16th tick: middle of every later bit

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Clocks per oversample tick; clamped to 1 so a too-fast baud still ticks.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, restartable.
// Latency: tick DIV clocks after restart.
// Backpressure: none; free-running.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count up, wrap after DIV-1, or jump back to 0 to realign on a start edge.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), 16x oversampled.
// Latency: char_ready one clock after the mid-stop-bit tick.
// Backpressure: none; pulses are fire-and-forget, char_data holds the last character.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] char_data,
  output logic       char_ready,
  output logic       framing_error,
  output logic       parity_error
);

  localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);

  rx_state_e  state_q, state_d;
  logic       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] char_data_q, char_data_d;
  logic       char_ready_q, char_ready_d;
  logic       framing_error_q, framing_error_d;
  logic       parity_error_q, parity_error_d;
`ifdef UART_RX_PARITY_EN
  logic       par_bad_q, par_bad_d;
`endif
  logic       restart, tick, rx_s, fall;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (restart),
    .tick    (tick)
  );

  assign rx_s = sync2_q;
  assign fall = prev_q & ~sync2_q;

  // Frame FSM: next-state, shift register and one-clock output pulses.
  always_comb begin
    sync1_d         = rx;
    sync2_d         = sync1_q;
    prev_d          = sync2_q;
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    char_data_d     = char_data_q;
    char_ready_d    = 1'b0;
    framing_error_d = 1'b0;
    parity_error_d  = 1'b0;
    restart         = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d       = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          restart    = 1'b1;
          tick_cnt_d = 4'd0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = 4'd0;
            bit_idx_d  = 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_d  = 1'b0;
`endif
            // A start bit that is high again at mid-bit was a glitch.
            state_d    = rx_s ? ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == LAST_TICK) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == LAST_TICK) begin
            // Even parity: data ones plus parity bit must be even.
            par_bad_d = rx_s ^ (^shift_q);
            state_d   = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == LAST_TICK) begin
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                parity_error_d = 1'b1;
              end else begin
                char_data_d  = shift_q;
                char_ready_d = 1'b1;
              end
`else
              char_data_d  = shift_q;
              char_ready_d = 1'b1;
`endif
              // Leave at mid-stop so a following start bit is not missed.
              state_d = ST_IDLE;
            end else begin
              framing_error_d = 1'b1;
              state_d         = ST_BREAK;
            end
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All receiver state; synchronizer and edge detector reset to idle-high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      prev_q          <= 1'b1;
      state_q         <= ST_IDLE;
      tick_cnt_q      <= 4'd0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      char_data_q     <= 8'h00;
      char_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q       <= 1'b0;
`endif
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      prev_q          <= prev_d;
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      char_data_q     <= char_data_d;
      char_ready_q    <= char_ready_d;
      framing_error_q <= framing_error_d;
      parity_error_q  <= parity_error_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q       <= par_bad_d;
`endif
    end
  end

  assign char_data     = char_data_q;
  assign char_ready    = char_ready_q;
  assign framing_error = framing_error_q;
  assign parity_error  = parity_error_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames driven at the nominal bit period, pulses
// collected by a monitor and compared with a frame-level outcome model.
// Build with UART_RX_PARITY_EN defined to cover the parity variant.
module tb_uart_receiver;

  localparam int CLK_HZ   = 50000000;
  localparam int BAUD     = 115200;
  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int K_CHAR = 0, K_FRAME = 1, K_PAR = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct { int kind; logic [7:0] data; } ev_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] char_data;
  logic       char_ready, framing_error, parity_error;

  ev_t        got_q[$];
  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         viol = 0;
  int         pulse_n;
  bit         prev_pulse = 1'b0;
  logic [7:0] last_char = 8'h00;

  always #10 clock = ~clock;

  uart_receiver dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .char_data     (char_data),
    .char_ready    (char_ready),
    .framing_error (framing_error),
    .parity_error  (parity_error)
  );

  // Monitor: record every output pulse and flag overlapping or back-to-back pulses.
  always @(negedge clock) begin
    if (reset_n) begin
      pulse_n = int'(char_ready) + int'(framing_error) + int'(parity_error);
      if (pulse_n > 1 || (pulse_n > 0 && prev_pulse)) viol++;
      if (char_ready)    got_q.push_back('{kind: K_CHAR,  data: char_data});
      if (framing_error) got_q.push_back('{kind: K_FRAME, data: char_data});
      if (parity_error)  got_q.push_back('{kind: K_PAR,   data: char_data});
      prev_pulse = (pulse_n > 0);
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic hold(input int clks);
    repeat (clks) @(posedge clock);
    #1;
  endtask

  // Reference: a frame yields exactly one outcome, framing error first, then parity.
  function automatic void model_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip);
    if (!stop_bit)                 exp_q.push_back('{kind: K_FRAME, data: last_char});
    else if (PAR_EN && par_flip)   exp_q.push_back('{kind: K_PAR,   data: last_char});
    else begin
      exp_q.push_back('{kind: K_CHAR, data: d});
      last_char = d;
    end
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip);
    model_frame(d, stop_bit, par_flip);
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(BIT_CLKS);
    end
    if (PAR_EN) begin
      rx = (^d) ^ par_flip;
      hold(BIT_CLKS);
    end
    rx = stop_bit;
    hold(BIT_CLKS);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    hold(n * BIT_CLKS);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    hold(5);
    total++;
    if (char_data !== 8'h00) begin bad++; $display("FAIL reset_char_data: got=%h want=00", char_data); end
    total++;
    if ({char_ready, framing_error, parity_error} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses: got=%b want=000", {char_ready, framing_error, parity_error});
    end
    reset_n = 1'b1;
    idle_bits(1);
  endtask

  task automatic test_single;
    send_frame(8'h53, 1'b1, 1'b0);
    idle_bits(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL single_count: got=%0d want=%0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data) begin
        bad++; $display("FAIL single_ev%0d: got kind=%0d data=%h want kind=%0d data=%h",
                        i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    hold(150);  // 3 us at 50 MHz
    idle_bits(2);
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL glitch_pulses: got=%0d want=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_framing;
    send_frame(8'hA5, 1'b0, 1'b0);
    rx = 1'b0;
    hold(20 * BIT_CLKS);
    idle_bits(1);
    send_frame(8'h3A, 1'b1, 1'b0);
    idle_bits(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL framing_count: got=%0d want=%0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data) begin
        bad++; $display("FAIL framing_ev%0d: got kind=%0d data=%h want kind=%0d data=%h",
                        i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] msg [4];
    msg = '{8'h53, 8'h33, 8'h0D, 8'h0A};
    foreach (msg[i]) send_frame(msg[i], 1'b1, 1'b0);
    idle_bits(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_count: got=%0d want=%0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data) begin
        bad++; $display("FAIL b2b_ev%0d: got kind=%0d data=%h want kind=%0d data=%h",
                        i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    total++;
    if (char_data !== 8'h0A) begin bad++; $display("FAIL b2b_hold: got=%h want=0a", char_data); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe;
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin rx = 1'b1; hold(BIT_CLKS); end
    hold(BIT_CLKS / 2);  // middle of data bit 4 of 0xFF
    reset_n = 1'b0;
    #1;
    total++;
    if (char_data !== 8'h00) begin bad++; $display("FAIL midreset_async: got=%h want=00", char_data); end
    last_char = 8'h00;
    hold(10);
    reset_n = 1'b1;
    idle_bits(5);
    send_frame(8'h30, 1'b1, 1'b0);
    idle_bits(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL midreset_count: got=%0d want=%0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data) begin
        bad++; $display("FAIL midreset_ev%0d: got kind=%0d data=%h want kind=%0d data=%h",
                        i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    for (int n = 0; n < 3; n++) begin
      logic [7:0] d;
      bit stop_ok, flip;
      d       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      flip    = PAR_EN && ($urandom_range(0, 3) == 0);
      send_frame(d, stop_ok, flip);
      // After a bad stop bit the line must return high before the next start.
      if (!stop_ok || $urandom_range(0, 1) == 1) idle_bits(1);
    end
    idle_bits(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_count: got=%0d want=%0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data) begin
        bad++; $display("FAIL random_ev%0d: got kind=%0d data=%h want kind=%0d data=%h",
                        i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    total++;
    if (char_data !== last_char) begin bad++; $display("FAIL random_hold: got=%h want=%h", char_data, last_char); end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h53, 1'b1, 1'b1);
    idle_bits(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL parity_count: got=%0d want=%0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data) begin
        bad++; $display("FAIL parity_ev%0d: got kind=%0d data=%h want kind=%0d data=%h",
                        i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    total++;
    if (char_data !== last_char) begin bad++; $display("FAIL parity_hold: got=%h want=%h", char_data, last_char); end
    got_q.delete(); exp_q.delete();
  endtask
`endif

  task automatic test_exclusive;
    total++;
    if (viol != 0) begin bad++; $display("FAIL pulse_exclusive: got=%0d overlaps want=0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
